// File: rtl/tx_lane_striper.sv
// Multi-lane transmit striper: gathers bytes into a group of `active` lanes and
// shifts each lane out MSB first, sending IDLE_SYM whenever no full group is staged.
module tx_lane_striper #(
  parameter int              LANES    = 4,
  parameter int              SW       = 8,
  parameter logic [SW-1:0]   IDLE_SYM = 8'hBC,
  parameter int              MW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [MW-1:0]    lane_mode,
  input  logic [SW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] lane_out,
  output logic [LANES-1:0] lane_en,
  output logic             sym_start,
  output logic             group_sent
);

  localparam int FW = $clog2(LANES + 1);
  localparam int BW = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SW - 1);

  logic [SW-1:0]    staging_q [LANES];
  logic [SW-1:0]    staging_d [LANES];
  logic [SW-1:0]    shift_q   [LANES];
  logic [SW-1:0]    shift_d   [LANES];
  logic [FW-1:0]    fill_q, fill_d;
  logic [BW-1:0]    bitCnt_q, bitCnt_d;
  logic [MW-1:0]    mode_q, mode_d;
  logic             symStart_q, symStart_d;
  logic             groupSent_q, groupSent_d;

  logic [FW-1:0]    activeCnt;
  logic             loadEdge;
  logic             accept;
  logic             groupReady;
  int               modePow;

  // Requested lane count is a power of two, clamped to the physical lane count.
  always_comb begin
    modePow   = 1 << mode_q;
    activeCnt = FW'(LANES);
    if (modePow < LANES) begin
      activeCnt = FW'(modePow);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_en[i]  = (FW'(i) < activeCnt);
      lane_out[i] = shift_q[i][SW-1] & lane_en[i];
    end
  end

  assign in_ready   = reset & enb & (fill_q < activeCnt);
  assign accept     = in_valid & in_ready;
  assign loadEdge   = enb & (bitCnt_q == LAST_BIT);
  assign groupReady = (fill_q == activeCnt);
  assign sym_start  = symStart_q;
  assign group_sent = groupSent_q;

  always_comb begin
    staging_d   = staging_q;
    shift_d     = shift_q;
    fill_d      = fill_q;
    bitCnt_d    = bitCnt_q;
    mode_d      = mode_q;
    symStart_d  = symStart_q;
    groupSent_d = groupSent_q;

    if (enb) begin
      bitCnt_d = loadEdge ? '0 : bitCnt_q + BW'(1);

      // in_ready is low while the group is full, so an accept never collides with a send.
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          if (FW'(i) == fill_q) begin
            staging_d[i] = in_data;
          end
        end
        fill_d = fill_q + FW'(1);
      end

      if (loadEdge) begin
        symStart_d  = 1'b1;
        groupSent_d = groupReady;
        for (int i = 0; i < LANES; i++) begin
          if (FW'(i) < activeCnt) begin
            shift_d[i] = groupReady ? staging_q[i] : IDLE_SYM;
          end else begin
            shift_d[i] = '0;
          end
        end
        if (groupReady) begin
          fill_d = '0;
        end
        // A lane-count change waits until no partial group would be re-striped.
        if (fill_d == '0) begin
          mode_d = lane_mode;
        end
      end else begin
        symStart_d  = 1'b0;
        groupSent_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          shift_d[i] = shift_q[i] << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        staging_q[i] <= '0;
        shift_q[i]   <= '0;
      end
      fill_q      <= '0;
      bitCnt_q    <= '0;
      mode_q      <= '0;
      symStart_q  <= 1'b0;
      groupSent_q <= 1'b0;
    end else begin
      staging_q   <= staging_d;
      shift_q     <= shift_d;
      fill_q      <= fill_d;
      bitCnt_q    <= bitCnt_d;
      mode_q      <= mode_d;
      symStart_q  <= symStart_d;
      groupSent_q <= groupSent_d;
    end
  end

endmodule
